// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router packet FIFO slice.
package router_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_DEPTH   = 16;
    localparam int unsigned DEF_LEN_LSB = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read handshake, status and error signals of the router packet FIFO.
interface router_pkt_fifo_if
    import router_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned LEN_LSB = DEF_LEN_LSB
);

    localparam int unsigned AW = clog2(DEPTH);

    logic                  soft_reset;
    logic                  write_enb;
    logic                  lfd_state;
    logic [DATA_W-1:0]     data_in;
    logic                  read_enb;
    logic [DATA_W-1:0]     data_out;
    logic                  data_valid;
    logic                  sop_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [AW:0]           fill_level;
    logic [DATA_W-LEN_LSB:0] pkt_cnt;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output soft_reset, write_enb, lfd_state, data_in, read_enb,
        input  data_out, data_valid, sop_out, full, empty, almost_full, almost_empty,
               fill_level, pkt_cnt, overflow, underflow
    );

    modport slave (
        input  soft_reset, write_enb, lfd_state, data_in, read_enb,
        output data_out, data_valid, sop_out, full, empty, almost_full, almost_empty,
               fill_level, pkt_cnt, overflow, underflow
    );

endinterface

// File: rtl/router_fifo_mem.sv
// Storage array: synchronous write, combinational read.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_W + 1,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                      clock,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet FIFO with header tagging, registered read port, status and sticky error flags.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned AF_LVL  = DEPTH - 2,
    parameter int unsigned AE_LVL  = 2,
    parameter int unsigned LEN_LSB = DEF_LEN_LSB
) (
    input  logic             clock,
    input  logic             resetn,
    router_pkt_fifo_if.slave bus
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = DATA_W - LEN_LSB + 1;
    localparam logic [AW:0] AF_THR = AF_LVL[AW:0];
    localparam logic [AW:0] AE_THR = AE_LVL[AW:0];

    logic [AW:0]       wr_ptr_q, rd_ptr_q, fill_q, fill_d;
    logic [PW-1:0]     pkt_q, pkt_d;
    logic [DATA_W-1:0] data_q;
    logic              sop_q, valid_q, ovf_q, udf_q;
    logic [DATA_W:0]   rd_word;
    logic              clear, full, empty, wr_acc, rd_acc;

    assign clear  = !resetn || bus.soft_reset;
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign wr_acc = bus.write_enb && !full && !clear;
    assign rd_acc = bus.read_enb && !empty && !clear;

    router_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data ({bus.lfd_state, bus.data_in}),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_word)
    );

    always_comb begin
        fill_d = fill_q;
        if (wr_acc && !rd_acc)      fill_d = fill_q + 1'b1;
        else if (rd_acc && !wr_acc) fill_d = fill_q - 1'b1;
    end

    // Header length counts payload words; +1 accounts for the trailing parity word.
    always_comb begin
        pkt_d = pkt_q;
        if (rd_acc) begin
            if (rd_word[DATA_W])  pkt_d = PW'(rd_word[DATA_W-1:LEN_LSB]) + PW'(1);
            else if (pkt_q != '0) pkt_d = pkt_q - PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            pkt_q    <= '0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                data_q   <= rd_word[DATA_W-1:0];
                sop_q    <= rd_word[DATA_W];
            end
            fill_q  <= fill_d;
            pkt_q   <= pkt_d;
            valid_q <= rd_acc;
            if (bus.write_enb && full) ovf_q <= 1'b1;
            // A read arriving with a write into an empty FIFO is deferred, not an error.
            if (bus.read_enb && empty && !bus.write_enb) udf_q <= 1'b1;
        end
    end

    assign bus.data_out     = data_q;
    assign bus.data_valid   = valid_q;
    assign bus.sop_out      = sop_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (fill_q >= AF_THR);
    assign bus.almost_empty = (fill_q <= AE_THR);
    assign bus.fill_level   = fill_q;
    assign bus.pkt_cnt      = pkt_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed self-checking bench for router_pkt_fifo at DATA_W=8, DEPTH=16.
module tb_router_pkt_fifo;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16), .LEN_LSB(2)) bus ();

    router_pkt_fifo #(
        .DATA_W  (8),
        .DEPTH   (16),
        .AF_LVL  (14),
        .AE_LVL  (2),
        .LEN_LSB (2)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.soft_reset = 0; bus.write_enb = 0; bus.read_enb = 0;
        bus.lfd_state = 0; bus.data_in = '0;
        resetn = 0;
        tick();
        resetn = 1;
    endtask

    task automatic write_word(input logic [7:0] d, input logic lfd);
        bus.write_enb = 1; bus.data_in = d; bus.lfd_state = lfd;
        tick();
        bus.write_enb = 0; bus.lfd_state = 0;
    endtask

    task automatic read_word();
        bus.read_enb = 1;
        tick();
        bus.read_enb = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %0b want 1", bus.empty); end
        tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL rst_full got %0b want 0", bus.full); end
        tests++; if (bus.fill_level !== 5'd0) begin fails++; $display("FAIL rst_fill got %0d want 0", bus.fill_level); end
        tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", bus.data_valid); end
        tests++; if (bus.data_out !== 8'h00) begin fails++; $display("FAIL rst_dout got %0h want 0", bus.data_out); end
        tests++; if (bus.pkt_cnt !== 7'd0) begin fails++; $display("FAIL rst_pkt got %0d want 0", bus.pkt_cnt); end
        tests++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin
            fails++; $display("FAIL rst_almost got ae=%0b af=%0b want ae=1 af=0", bus.almost_empty, bus.almost_full);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] d;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            d = 8'(i);
            write_word(d, 1'b0);
            if (i == 2) begin
                tests++; if (bus.almost_empty !== 1'b1) begin fails++; $display("FAIL ae_at2 got %0b want 1", bus.almost_empty); end
            end
            if (i == 3) begin
                tests++; if (bus.almost_empty !== 1'b0) begin fails++; $display("FAIL ae_at3 got %0b want 0", bus.almost_empty); end
            end
            if (i == 13) begin
                tests++; if (bus.almost_full !== 1'b0) begin fails++; $display("FAIL af_at13 got %0b want 0", bus.almost_full); end
            end
            if (i == 14) begin
                tests++; if (bus.almost_full !== 1'b1) begin fails++; $display("FAIL af_at14 got %0b want 1", bus.almost_full); end
            end
            if (i == 15) begin
                tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL full_at15 got %0b want 0", bus.full); end
            end
        end
        tests++; if (bus.full !== 1'b1 || bus.fill_level !== 5'd16) begin
            fails++; $display("FAIL full_at16 got full=%0b fill=%0d want 1/16", bus.full, bus.fill_level);
        end
        write_word(8'hFF, 1'b0);
        tests++; if (bus.overflow !== 1'b1 || bus.fill_level !== 5'd16) begin
            fails++; $display("FAIL overflow got ovf=%0b fill=%0d want 1/16", bus.overflow, bus.fill_level);
        end
        for (int i = 1; i <= 16; i++) begin
            read_word();
            tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'(i)) begin
                fails++; $display("FAIL drain_%0d got v=%0b d=%0h want v=1 d=%0h", i, bus.data_valid, bus.data_out, i);
            end
        end
        tick();
        tests++; if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h10 || bus.empty !== 1'b1) begin
            fails++; $display("FAIL idle_hold got v=%0b d=%0h e=%0b want 0/10/1", bus.data_valid, bus.data_out, bus.empty);
        end
    endtask

    task automatic test_packet();
        logic [7:0] pay [4];
        pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3; pay[3] = 8'h5E;
        do_reset();
        write_word(8'h0C, 1'b1);
        for (int i = 0; i < 4; i++) write_word(pay[i], 1'b0);
        read_word();
        tests++; if (bus.pkt_cnt !== 7'd4 || bus.sop_out !== 1'b1 || bus.data_out !== 8'h0C) begin
            fails++; $display("FAIL hdr got pkt=%0d sop=%0b d=%0h want 4/1/0c", bus.pkt_cnt, bus.sop_out, bus.data_out);
        end
        for (int i = 0; i < 4; i++) begin
            read_word();
            tests++; if (bus.pkt_cnt !== 7'(3 - i) || bus.sop_out !== 1'b0 || bus.data_out !== pay[i]) begin
                fails++; $display("FAIL pay_%0d got pkt=%0d sop=%0b d=%0h want %0d/0/%0h",
                                  i, bus.pkt_cnt, bus.sop_out, bus.data_out, 3 - i, pay[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] v;
        do_reset();
        for (int i = 1; i <= 16; i++) write_word(8'(i), 1'b0);
        bus.write_enb = 1; bus.data_in = 8'h77; bus.read_enb = 1;
        tick();
        bus.write_enb = 0; bus.read_enb = 0;
        tests++; if (bus.fill_level !== 5'd15 || bus.full !== 1'b0 || bus.data_out !== 8'h01) begin
            fails++; $display("FAIL rw_full got fill=%0d full=%0b d=%0h want 15/0/01", bus.fill_level, bus.full, bus.data_out);
        end
        do_reset();
        bus.write_enb = 1; bus.data_in = 8'h3C; bus.read_enb = 1;
        tick();
        bus.write_enb = 0; bus.read_enb = 0;
        tests++; if (bus.fill_level !== 5'd1 || bus.data_valid !== 1'b0 || bus.underflow !== 1'b0) begin
            fails++; $display("FAIL rw_empty got fill=%0d v=%0b udf=%0b want 1/0/0", bus.fill_level, bus.data_valid, bus.underflow);
        end
        do_reset();
        read_word();
        tests++; if (bus.underflow !== 1'b1 || bus.data_valid !== 1'b0 || bus.fill_level !== 5'd0) begin
            fails++; $display("FAIL underflow got udf=%0b v=%0b fill=%0d want 1/0/0", bus.underflow, bus.data_valid, bus.fill_level);
        end
        do_reset();
        for (int i = 0; i < 40; i++) begin
            v = 8'(i * 5 + 1);
            write_word(v, 1'b0);
            read_word();
            tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== v) begin
                fails++; $display("FAIL wrap_%0d got v=%0b d=%0h want 1/%0h", i, bus.data_valid, bus.data_out, v);
            end
        end
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %0b want 1", bus.empty); end
    endtask

    task automatic test_soft_reset();
        do_reset();
        for (int i = 0; i < 8; i++) write_word(8'(8'h40 + i), 1'b0);
        write_word(8'h0C, 1'b1);
        write_word(8'hA1, 1'b0); write_word(8'hA2, 1'b0); write_word(8'hA3, 1'b0);
        write_word(8'h5E, 1'b0);
        for (int i = 0; i < 3; i++) write_word(8'(8'h50 + i), 1'b0);
        write_word(8'hEE, 1'b0);
        for (int i = 0; i < 11; i++) read_word();
        tests++; if (bus.fill_level !== 5'd5 || bus.pkt_cnt !== 7'd2 || bus.overflow !== 1'b1) begin
            fails++; $display("FAIL sr_pre got fill=%0d pkt=%0d ovf=%0b want 5/2/1", bus.fill_level, bus.pkt_cnt, bus.overflow);
        end
        bus.soft_reset = 1; bus.write_enb = 1; bus.data_in = 8'h99; bus.read_enb = 1;
        tick();
        bus.soft_reset = 0; bus.write_enb = 0; bus.read_enb = 0;
        tests++; if (bus.empty !== 1'b1 || bus.fill_level !== 5'd0 || bus.pkt_cnt !== 7'd0) begin
            fails++; $display("FAIL sr_clear got e=%0b fill=%0d pkt=%0d want 1/0/0", bus.empty, bus.fill_level, bus.pkt_cnt);
        end
        tests++; if (bus.overflow !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin
            fails++; $display("FAIL sr_flags got ovf=%0b v=%0b d=%0h want 0/0/00", bus.overflow, bus.data_valid, bus.data_out);
        end
        write_word(8'h6B, 1'b0);
        read_word();
        tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h6B) begin
            fails++; $display("FAIL sr_after got v=%0b d=%0h want 1/6b", bus.data_valid, bus.data_out);
        end
    endtask

    initial begin
        bus.soft_reset = 0; bus.write_enb = 0; bus.read_enb = 0;
        bus.lfd_state = 0; bus.data_in = '0;
        tick();
        test_reset();
        test_fill_drain();
        test_packet();
        test_simultaneous();
        test_soft_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
